// File: rtl/pipe_pkg.sv
// Shared occupancy-state encoding and default widths for the skid-buffered
// pipeline register.
package pipe_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_CTRL_W = 24;

  // The encoding doubles as the held-entry count driven out on OCCUPANCY.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } occ_state_e;

endpackage

// File: rtl/pipeline_skid_fsm.sv
// Occupancy FSM for the two-entry skid register: steers datapath loads and
// produces a registered ready so upstream never sees a path from OUT_READY.
module pipeline_skid_fsm
  import pipe_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       in_valid_i,
  input  logic       out_ready_i,
  input  logic       flush_i,
  output logic       load_main_o,
  output logic       load_skid_o,
  output logic       skid_to_main_o,
  output logic       in_ready_o,
  output logic       out_valid_o,
  output logic [1:0] occupancy_o
);

  occ_state_e state_q, state_d;
  logic       in_ready_q, in_ready_d;
  logic       accept, consume;

  assign out_valid_o = (state_q != ST_EMPTY);
  assign accept      = in_valid_i & in_ready_q;
  assign consume     = out_valid_o & out_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    load_main_o    = 1'b0;
    load_skid_o    = 1'b0;
    skid_to_main_o = 1'b0;

    // Flush wins outright; suppressing loads keeps OUT_DATA frozen in the bubble.
    if (flush_i) begin
      state_d = ST_EMPTY;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            load_main_o = 1'b1;
            state_d     = ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && consume) begin
            load_main_o = 1'b1;
          end else if (accept) begin
            load_skid_o = 1'b1;
            state_d     = ST_FULL;
          end else if (consume) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (consume) begin
            skid_to_main_o = 1'b1;
            state_d        = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end

    in_ready_d = (state_d != ST_FULL);
  end

  assign in_ready_o  = in_ready_q;
  assign occupancy_o = state_q;

endmodule

// File: rtl/pipeline_skid_reg.sv
// Two-entry skid pipeline register between instruction pipeline stages:
// full throughput, registered IN_READY, in-order delivery, synchronous flush.
module pipeline_skid_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W              = DEF_DATA_W,
  parameter int CTRL_W              = DEF_CTRL_W,
  parameter bit ZERO_CTRL_ON_BUBBLE = 1'b1
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [DATA_W-1:0] IN_DATA,
  input  logic [CTRL_W-1:0] IN_CTRL,
  input  logic              FLUSH,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [DATA_W-1:0] OUT_DATA,
  output logic [CTRL_W-1:0] OUT_CTRL,
  output logic [1:0]        OCCUPANCY
);

  logic              load_main, load_skid, skid_to_main;
  logic [DATA_W-1:0] main_data_q, skid_data_q;
  logic [CTRL_W-1:0] main_ctrl_q, skid_ctrl_q;

  pipeline_skid_fsm u_fsm (
    .clk_i          (CLK),
    .rst_ni         (RESET_N),
    .in_valid_i     (IN_VALID),
    .out_ready_i    (OUT_READY),
    .flush_i        (FLUSH),
    .load_main_o    (load_main),
    .load_skid_o    (load_skid),
    .skid_to_main_o (skid_to_main),
    .in_ready_o     (IN_READY),
    .out_valid_o    (OUT_VALID),
    .occupancy_o    (OCCUPANCY)
  );

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      main_data_q <= '0;
      main_ctrl_q <= '0;
    end else if (load_main) begin
      main_data_q <= IN_DATA;
      main_ctrl_q <= IN_CTRL;
    end else if (skid_to_main) begin
      main_data_q <= skid_data_q;
      main_ctrl_q <= skid_ctrl_q;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
    end else if (load_skid) begin
      skid_data_q <= IN_DATA;
      skid_ctrl_q <= IN_CTRL;
    end
  end

  // Gating control in a bubble keeps stale write/mem enables from leaking out.
  assign OUT_DATA = main_data_q;
  assign OUT_CTRL = (ZERO_CTRL_ON_BUBBLE && !OUT_VALID) ? '0 : main_ctrl_q;

endmodule
